// File: rtl/vram_swap_scheduler_pkg.sv
// Shared types and defaults for the VRAM double-buffer swap sequencer.
package vram_sched_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4095;
  localparam int unsigned DEFAULT_FRAME_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SWAP,
    SYNC,
    WAIT_DONE,
    ACK
  } vram_sched_state_t;

  // Bits needed for a timer that must be able to hold max_count itself.
  function automatic int unsigned timer_w(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/vram_swap_scheduler_if.sv
// CPU / PPU / sync-writer handshake bundle for vram_swap_scheduler.
interface vram_swap_scheduler_if
  import vram_sched_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = DEFAULT_FRAME_CNT_W
);

  logic                   cpu_update_req;
  logic                   vblank_start;
  logic                   sync_done;
  logic                   err_clr;
  logic                   swap;
  logic                   sync;
  logic                   cpu_wr_block;
  logic                   update_pending;
  logic                   frame_ack;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic                   timeout_err;

  modport master (
    output cpu_update_req, vblank_start, sync_done, err_clr,
    input  swap, sync, cpu_wr_block, update_pending, frame_ack,
           frame_count, timeout_err
  );

  modport slave (
    input  cpu_update_req, vblank_start, sync_done, err_clr,
    output swap, sync, cpu_wr_block, update_pending, frame_ack,
           frame_count, timeout_err
  );

endinterface

// File: rtl/vram_swap_scheduler_watchdog.sv
// Loadable saturating up-counter with clear/enable; flags when it reaches TERM.
module vram_sched_watchdog #(
  parameter int unsigned W    = 12,
  parameter int unsigned TERM = 4094
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TERM));

endmodule

// File: rtl/vram_swap_scheduler.sv
// Per-frame VRAM sequencer: vblank-aligned swap, consumer->producer resync,
// CPU write blocking and a watchdog on the sync writer.
module vram_swap_scheduler
  import vram_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned FRAME_CNT_W    = DEFAULT_FRAME_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  vram_swap_scheduler_if.slave bus
);

  localparam int unsigned TIMER_W = timer_w(TIMEOUT_CYCLES);

  vram_sched_state_t      state;
  logic                   swap_q;
  logic                   sync_q;
  logic                   block_q;
  logic                   pending_q;
  logic                   ack_q;
  logic                   err_q;
  logic                   requeue_q;
  logic [FRAME_CNT_W-1:0] count_q;
  logic                   wd_clr;
  logic                   wd_en;
  logic                   wd_expired;

  // Timer is zeroed during SYNC so it counts only WAIT_DONE cycles.
  always_comb begin
    wd_clr = (state == SYNC);
    wd_en  = (state == WAIT_DONE);
  end

  vram_sched_watchdog #(
    .W    (TIMER_W),
    .TERM (TIMEOUT_CYCLES - 1)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (wd_en),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      swap_q    <= 1'b0;
      sync_q    <= 1'b0;
      block_q   <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      requeue_q <= 1'b0;
      count_q   <= '0;
    end else begin
      swap_q <= 1'b0;
      sync_q <= 1'b0;
      ack_q  <= 1'b0;
      // Clear first so a timeout later in this block overrides it.
      if (bus.err_clr) err_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cpu_update_req) begin
            state     <= ARMED;
            pending_q <= 1'b1;
            block_q   <= 1'b1;
          end
        end

        ARMED: begin
          if (bus.vblank_start) begin
            state     <= SWAP;
            swap_q    <= 1'b1;
            pending_q <= 1'b0;
          end
        end

        SWAP: begin
          state  <= SYNC;
          sync_q <= 1'b1;
          if (bus.cpu_update_req) requeue_q <= 1'b1;
        end

        SYNC: begin
          state <= WAIT_DONE;
          if (bus.cpu_update_req) requeue_q <= 1'b1;
        end

        WAIT_DONE: begin
          if (bus.sync_done) begin
            state   <= ACK;
            ack_q   <= 1'b1;
            block_q <= 1'b0;
            count_q <= count_q + FRAME_CNT_W'(1);
            if (bus.cpu_update_req) requeue_q <= 1'b1;
          end else if (wd_expired) begin
            state     <= IDLE;
            err_q     <= 1'b1;
            block_q   <= 1'b0;
            requeue_q <= 1'b0;
          end else if (bus.cpu_update_req) begin
            requeue_q <= 1'b1;
          end
        end

        ACK: begin
          requeue_q <= 1'b0;
          if (requeue_q || bus.cpu_update_req) begin
            state     <= ARMED;
            pending_q <= 1'b1;
            block_q   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          pending_q <= 1'b0;
          block_q   <= 1'b0;
          requeue_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.swap           = swap_q;
  assign bus.sync           = sync_q;
  assign bus.cpu_wr_block   = block_q;
  assign bus.update_pending = pending_q;
  assign bus.frame_ack      = ack_q;
  assign bus.frame_count    = count_q;
  assign bus.timeout_err    = err_q;

endmodule

// File: tb/tb_vram_swap_scheduler.sv
// Scoreboard bench for vram_swap_scheduler: expected swap/sync/ack pulses are
// queued with their cycle and frame count, and matched as the DUT emits them.
module tb_vram_swap_scheduler;
  import vram_sched_pkg::*;

  localparam int unsigned TO  = DEFAULT_TIMEOUT_CYCLES;
  localparam int unsigned FCW = 2;
  localparam int          CNT_MOD = 1 << FCW;

  typedef struct {
    int kind;   // 0 swap, 1 sync, 2 frame_ack
    int c;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   frames = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_swap_scheduler_if #(.FRAME_CNT_W(FCW)) bus ();

  vram_swap_scheduler #(
    .TIMEOUT_CYCLES (TO),
    .FRAME_CNT_W    (FCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int k, input int c, input int n);
    ev_t e;
    e.kind = k;
    e.c    = c;
    e.cnt  = n;
    sb.push_back(e);
  endtask

  task automatic got_pulse(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      check_eq("unexp_pulse", k, -1);
    end else begin
      e = sb.pop_front();
      check_eq("pulse_kind", k, e.kind);
      check_eq("pulse_cyc", cyc, e.c);
      if (k == 2) check_eq("ack_count", int'(bus.frame_count), e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (bus.swap === 1'b1)      got_pulse(0);
    if (bus.sync === 1'b1)      got_pulse(1);
    if (bus.frame_ack === 1'b1) got_pulse(2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_swap"}, int'(bus.swap), 0);
    check_eq({tag, "_sync"}, int'(bus.sync), 0);
    check_eq({tag, "_blk"},  int'(bus.cpu_wr_block), 0);
    check_eq({tag, "_pend"}, int'(bus.update_pending), 0);
    check_eq({tag, "_ack"},  int'(bus.frame_ack), 0);
    check_eq({tag, "_cnt"},  int'(bus.frame_count), 0);
    check_eq({tag, "_err"},  int'(bus.timeout_err), 0);
  endtask

  // From IDLE: request, vblank after vb cycles, sync_done dd cycles after sync.
  task automatic run_frame(input int vb, input int dd);
    int v;
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    repeat (vb) tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start = 1'b0;
    while (cyc < v + 2 + dd) tick();
    bus.sync_done = 1'b1;
    frames++;
    push_ev(2, cyc + 1, frames % CNT_MOD);
    tick();
    bus.sync_done = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cyc %0d expected finish", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int k0;
    int v;
    int wrap_exp [5];
    wrap_exp = '{1, 2, 3, 0, 1};

    rst = 1'b1;
    bus.cpu_update_req = 1'b0;
    bus.vblank_start   = 1'b0;
    bus.sync_done      = 1'b0;
    bus.err_clr        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_quiet("rst");

    // Basic frame with a ~2050-cycle copy.
    repeat (3) tick();
    k0 = cyc;
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    check_eq("s1_pend", int'(bus.update_pending), 1);
    check_eq("s1_blk", int'(bus.cpu_wr_block), 1);
    while (cyc < k0 + 15) tick();
    check_eq("s1_pend_hold", int'(bus.update_pending), 1);
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start = 1'b0;
    check_eq("s1_pend_drop", int'(bus.update_pending), 0);
    check_eq("s1_blk_swap", int'(bus.cpu_wr_block), 1);
    while (cyc < v + 2 + 2050) tick();
    check_eq("s1_blk_wait", int'(bus.cpu_wr_block), 1);
    bus.sync_done = 1'b1;
    frames++;
    push_ev(2, cyc + 1, frames % CNT_MOD);
    tick();
    bus.sync_done = 1'b0;
    check_eq("s1_blk_ack", int'(bus.cpu_wr_block), 0);
    check_eq("s1_cnt", int'(bus.frame_count), 1);
    tick();
    check_eq("s1_idle_pend", int'(bus.update_pending), 0);

    // Request and vblank in the same cycle: vblank must not be consumed.
    k0 = cyc;
    bus.cpu_update_req = 1'b1;
    bus.vblank_start   = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    bus.vblank_start   = 1'b0;
    check_eq("s2_pend", int'(bus.update_pending), 1);
    while (cyc < k0 + 30) tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start = 1'b0;
    while (cyc < v + 4) tick();
    bus.sync_done = 1'b1;
    frames++;
    push_ev(2, cyc + 1, frames % CNT_MOD);
    tick();
    bus.sync_done = 1'b0;
    tick();

    // Requeue: requests during SWAP and WAIT_DONE collapse into one re-arm.
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start   = 1'b0;
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.cpu_update_req = 1'b1;
      tick();
      bus.cpu_update_req = 1'b0;
    end
    bus.sync_done = 1'b1;
    frames++;
    push_ev(2, cyc + 1, frames % CNT_MOD);
    tick();
    bus.sync_done = 1'b0;
    check_eq("s3_ack_blk", int'(bus.cpu_wr_block), 0);
    tick();
    check_eq("s3_rearm_pend", int'(bus.update_pending), 1);
    check_eq("s3_rearm_blk", int'(bus.cpu_wr_block), 1);
    repeat (3) tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start = 1'b0;
    while (cyc < v + 3) tick();
    bus.sync_done = 1'b1;
    frames++;
    push_ev(2, cyc + 1, frames % CNT_MOD);
    tick();
    bus.sync_done = 1'b0;
    tick();
    check_eq("s3_idle_pend", int'(bus.update_pending), 0);
    check_eq("s3_idle_blk", int'(bus.cpu_wr_block), 0);
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start = 1'b0;
    repeat (3) tick();
    check_eq("s3_vb_idle_pend", int'(bus.update_pending), 0);

    // Stale sync_done held high from IDLE through SYNC must not end WAIT_DONE early.
    bus.sync_done = 1'b1;
    repeat (3) tick();
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start   = 1'b0;
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    frames++;
    push_ev(2, v + 4, frames % CNT_MOD);
    tick();
    bus.vblank_start = 1'b0;
    while (cyc < v + 4) tick();
    bus.sync_done = 1'b0;
    tick();

    // Timeout: no sync_done; a pending requeue is dropped; set beats err_clr.
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start = 1'b0;
    while (cyc < v + 8) tick();
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    while (cyc < v + 2 + TO) tick();
    check_eq("to_err_before", int'(bus.timeout_err), 0);
    check_eq("to_blk_before", int'(bus.cpu_wr_block), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_eq("to_err_set", int'(bus.timeout_err), 1);
    check_eq("to_blk_after", int'(bus.cpu_wr_block), 0);
    check_eq("to_cnt_same", int'(bus.frame_count), frames % CNT_MOD);
    repeat (3) tick();
    check_eq("to_no_requeue", int'(bus.update_pending), 0);
    check_eq("to_err_sticky", int'(bus.timeout_err), 1);
    run_frame(2, 5);
    check_eq("to_err_keep", int'(bus.timeout_err), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_eq("to_err_clr", int'(bus.timeout_err), 0);

    // Reset in WAIT_DONE aborts; later stimulus in IDLE produces nothing.
    bus.cpu_update_req = 1'b1;
    tick();
    bus.cpu_update_req = 1'b0;
    tick();
    bus.vblank_start = 1'b1;
    v = cyc;
    push_ev(0, v + 1, 0);
    push_ev(1, v + 2, 0);
    tick();
    bus.vblank_start = 1'b0;
    while (cyc < v + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("mrst");
    frames = 0;
    bus.sync_done    = 1'b1;
    bus.vblank_start = 1'b1;
    repeat (5) tick();
    bus.sync_done    = 1'b0;
    bus.vblank_start = 1'b0;
    check_quiet("mrst_after");

    // Five frames on a 2-bit counter wrap 3 -> 0.
    for (int i = 0; i < 5; i++) begin
      run_frame(4, 3);
      check_eq("wrap_cnt", int'(bus.frame_count), wrap_exp[i]);
    end

    repeat (5) tick();
    check_eq("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
